arm_motion_sequencer: RTL and testbench
=======================================

# arm_motion_sequencer

Motion controller between the position sources (arm position memory, accelerometer) and the servo PWM / VGA / display datapath. Sequences playback of stored arm poses through a request/acknowledge fetch port, or live-tracks the accelerometer. In both modes every axis is slew-rate limited toward its target, so the servos never jump. Its `x_cmd`/`y_cmd`/`z_cmd` outputs replace the raw source multiplexer feeding `pwm_servos`.

## Interface
- `DATA_WIDTH`, 10: width of each axis value, unsigned, 0..2^DATA_WIDTH-1.
- `ADDRESS_WIDTH`, 4: pose memory address width.
- `NUM_POINTS`, 16: number of poses played, addresses 0..NUM_POINTS-1, with NUM_POINTS ≤ 2^ADDRESS_WIDTH.
- `TICK_DIV`, 500_000: clk cycles per motion tick (100 Hz at 50 MHz); must be ≥ 2.
- `STEP_MAX`, 8: maximum change per axis per tick.
- `DWELL_TICKS`, 50: ticks held at each reached pose.
- `HOME`, 512: reset value of every axis command.
- `clk` input 1: system clock.
- `rst` input 1: synchronous reset, active-low.
- `start` input 1: one-shot pulse that starts playback.
- `stop` input 1: one-shot pulse that aborts playback.
- `select_source` input 1: 1 selects accelerometer tracking, 0 selects memory playback.
- `mem_req` output 1: fetch request.
- `mem_addr` output ADDRESS_WIDTH: pose address, held stable while `mem_req`=1.
- `mem_ack` input 1: `mem_x`/`mem_y`/`mem_z` are valid this cycle.
- `mem_x`, `mem_y`, `mem_z` input DATA_WIDTH each: pose data.
- `accel_x`, `accel_y`, `accel_z` input DATA_WIDTH each: accelerometer values.
- `x_cmd`, `y_cmd`, `z_cmd` output DATA_WIDTH each: slewed servo commands, registered.
- `busy` output 1: high in FETCH, MOVE, DWELL, TRACK.
- `done` output 1: one-cycle pulse at the end of playback.
- `state` output 3: current state encoding, for LEDs and debug.

## Operation
States and encoding: IDLE=0, FETCH=1, MOVE=2, DWELL=3, TRACK=4, DONE=5.
- **IDLE:**
  - If `select_source`=1, go to TRACK.
  - Otherwise, if `start`=1, set `mem_addr`=0 and go to FETCH.
  - If both conditions hold in the same cycle, TRACK wins.
- **FETCH:**
  - `mem_req`=1 until the cycle after `mem_ack`.
  - On the ack edge, latch the targets tx/ty/tz from `mem_*`, then go to MOVE.
  - No timeout; waits indefinitely.
- **MOVE:**
  - On each tick, every axis steps toward its target: cmd ± min(|target−cmd|, STEP_MAX).
  - Arithmetic is done at DATA_WIDTH+1 bits. Commands never overshoot and never wrap.
  - When all three axes equal their targets, go to DWELL. This is checked every cycle, not only on ticks.
- **DWELL:**
  - Count DWELL_TICKS ticks.
  - At the end: if `mem_addr`=NUM_POINTS−1, go to DONE; otherwise increment `mem_addr` and go to FETCH.
- **DONE:** `done`=1 for one cycle, then go to IDLE. `mem_addr` returns to 0.
- **TRACK:**
  - Targets load from `accel_*` every cycle. The same slew rule as MOVE applies on ticks.
  - When `select_source`=0, go to IDLE.
- **Abort:**
  - `stop`=1 or `select_source`=1 in FETCH, MOVE or DWELL forces IDLE on the next cycle.
  - `mem_req` drops and commands hold their values. From IDLE, `select_source`=1 then enters TRACK.
  - `stop` has priority over every other transition.
- `start` outside IDLE is ignored. `stop` in IDLE or TRACK is ignored.
- Commands change only on tick cycles, and only in MOVE or TRACK. They hold in every other state.

## Timing
- **Reset** (`rst`=0 at a rising edge):
  - State=IDLE, `x_cmd`/`y_cmd`/`z_cmd`=HOME, targets=HOME.
  - `mem_addr`=0, `mem_req`=0, `busy`=0, `done`=0.
  - Tick counter=0, dwell counter=0.
  - Reset mid-fetch drops `mem_req` immediately.
- **Tick:** the free-running counter counts 0..TICK_DIV−1 and pulses the tick on TICK_DIV−1. It runs in all states.
- **Start:** `start` at cycle n in IDLE gives `mem_req`=1 and `busy`=1 at n+1.
- **Fetch handshake:** `mem_ack`=1 at cycle m gives state MOVE and `mem_req`=0 at m+1. If `mem_ack` arrives in the same cycle `mem_req` rises, it is accepted.
- **Slew:** a tick at cycle t updates the commands, visible at t+1.
- **Done:** `done` is high exactly one cycle, the cycle the state register reads DONE.

## Configuration
- `SEQ_LOOP_EN` defined: after the DWELL of address NUM_POINTS−1, `mem_addr` wraps to 0 and the block goes to FETCH. DONE is never entered and `done` never pulses. Only `stop` or `select_source` ends playback.
- `SEQ_LOOP_EN` undefined: one pass, then DONE, as specified in Operation.

## Test plan
Bench parameters: TICK_DIV=4, STEP_MAX=8, DWELL_TICKS=2, NUM_POINTS=3, with a memory model that acks 2 cycles after `mem_req`.
- **Reset:** hold `rst`=0 for 3 cycles → all cmds=512, `state`=0, `mem_req`=0, `busy`=0.
- **Playback:** pose 0 = (530, 500, 512), `start` pulse → x reaches 530 after 3 ticks (520, 528, 530); y reaches 500 after 2 ticks (504, 500). Addresses 0, 1, 2 are fetched in order. `done` pulses once; `state` returns to 0 and `mem_addr`=0.
- **Stop mid-MOVE:** `stop` during MOVE → IDLE next cycle, cmds frozen, no further `mem_req`.
- **Tracking:** `select_source`=1 with accel=(1023, 0, 512) from cmds at 512 → x rises by 8 per tick and y falls by 8 per tick, with no wrap. At x=1020 the next step is 3.
- **Priority:** `start` and `select_source`=1 in the same IDLE cycle → TRACK, `mem_req` stays 0. A `start` pulse in TRACK is ignored.
- **`SEQ_LOOP_EN` defined:** after address 2, `mem_addr` wraps to 0 with no `done` pulse; `stop` terminates to IDLE.

Source files
------------

// File: rtl/arm_motion_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : arm_motion_sequencer
// Purpose  : Plays back stored arm poses or tracks the accelerometer, with
//            every axis slew-rate limited toward its target.
// Options  : define SEQ_LOOP_EN to loop playback forever instead of one pass.
// Revision : 1.0 - initial release
// ============================================================================
module arm_motion_sequencer #(
    parameter int DATA_WIDTH    = 10,
    parameter int ADDRESS_WIDTH = 4,
    parameter int NUM_POINTS    = 16,
    parameter int TICK_DIV      = 500_000,
    parameter int STEP_MAX      = 8,
    parameter int DWELL_TICKS   = 50,
    parameter int HOME          = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     select_source,
    output logic                     mem_req,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic                     mem_ack,
    input  logic [DATA_WIDTH-1:0]    mem_x,
    input  logic [DATA_WIDTH-1:0]    mem_y,
    input  logic [DATA_WIDTH-1:0]    mem_z,
    input  logic [DATA_WIDTH-1:0]    accel_x,
    input  logic [DATA_WIDTH-1:0]    accel_y,
    input  logic [DATA_WIDTH-1:0]    accel_z,
    output logic [DATA_WIDTH-1:0]    x_cmd,
    output logic [DATA_WIDTH-1:0]    y_cmd,
    output logic [DATA_WIDTH-1:0]    z_cmd,
    output logic                     busy,
    output logic                     done,
    output logic [2:0]               state
);

    localparam int c_tick_w  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_dwell_w = $clog2(DWELL_TICKS + 1);
    localparam logic [DATA_WIDTH:0] c_step = (DATA_WIDTH + 1)'(STEP_MAX);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_MOVE  = 3'd2,
        S_DWELL = 3'd3,
        S_TRACK = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                   r_state, w_state_nxt;
    logic [c_tick_w-1:0]      r_tick_cnt;
    logic [c_dwell_w-1:0]     r_dwell_cnt;
    logic [ADDRESS_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0]    r_tgt_x, r_tgt_y, r_tgt_z;
    logic [DATA_WIDTH-1:0]    r_x, r_y, r_z;
    logic [DATA_WIDTH-1:0]    w_tgt_x, w_tgt_y, w_tgt_z;
    logic                     w_tick, w_abort, w_reached, w_dwell_end, w_last, w_slew_en;

    // Step one axis toward its target; the extra bit keeps the compare and add wrap-free.
    function automatic logic [DATA_WIDTH-1:0] slew(input logic [DATA_WIDTH-1:0] cur,
                                                   input logic [DATA_WIDTH-1:0] tgt);
        logic [DATA_WIDTH:0] c, t, d, s, r;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        if (t > c) begin
            d = t - c;
            s = (d > c_step) ? c_step : d;
            r = c + s;
        end else begin
            d = c - t;
            s = (d > c_step) ? c_step : d;
            r = c - s;
        end
        return r[DATA_WIDTH-1:0];
    endfunction

    assign w_tick      = (r_tick_cnt == c_tick_w'(TICK_DIV - 1));
    assign w_abort     = stop || select_source;
    assign w_reached   = (r_x == r_tgt_x) && (r_y == r_tgt_y) && (r_z == r_tgt_z);
    assign w_dwell_end = w_tick && (r_dwell_cnt == c_dwell_w'(DWELL_TICKS - 1));
    assign w_last      = (r_mem_addr == ADDRESS_WIDTH'(NUM_POINTS - 1));
    // Tracking slews straight toward the live accelerometer value.
    assign w_tgt_x     = (r_state == S_TRACK) ? accel_x : r_tgt_x;
    assign w_tgt_y     = (r_state == S_TRACK) ? accel_y : r_tgt_y;
    assign w_tgt_z     = (r_state == S_TRACK) ? accel_z : r_tgt_z;
    assign w_slew_en   = w_tick && (((r_state == S_MOVE) && !w_abort) || (r_state == S_TRACK));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (select_source)  w_state_nxt = S_TRACK;
                else if (start)     w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (w_abort)        w_state_nxt = S_IDLE;
                else if (mem_ack)   w_state_nxt = S_MOVE;
            end
            S_MOVE: begin
                if (w_abort)        w_state_nxt = S_IDLE;
                else if (w_reached) w_state_nxt = S_DWELL;
            end
            S_DWELL: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_dwell_end) begin
`ifdef SEQ_LOOP_EN
                    w_state_nxt = S_FETCH;
`else
                    w_state_nxt = w_last ? S_DONE : S_FETCH;
`endif
                end
            end
            S_TRACK: begin
                if (!select_source) w_state_nxt = S_IDLE;
            end
            S_DONE:                 w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_tick_cnt  <= '0;
            r_dwell_cnt <= '0;
            r_mem_addr  <= '0;
            r_tgt_x     <= DATA_WIDTH'(HOME);
            r_tgt_y     <= DATA_WIDTH'(HOME);
            r_tgt_z     <= DATA_WIDTH'(HOME);
            r_x         <= DATA_WIDTH'(HOME);
            r_y         <= DATA_WIDTH'(HOME);
            r_z         <= DATA_WIDTH'(HOME);
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;

            if (r_state != S_DWELL) r_dwell_cnt <= '0;
            else if (w_tick)        r_dwell_cnt <= r_dwell_cnt + 1'b1;

            if (r_state == S_IDLE && start && !select_source) begin
                r_mem_addr <= '0;
            end else if (r_state == S_DWELL && !w_abort && w_dwell_end) begin
                r_mem_addr <= w_last ? '0 : r_mem_addr + 1'b1;
            end

            if (r_state == S_FETCH && mem_ack) begin
                r_tgt_x <= mem_x;
                r_tgt_y <= mem_y;
                r_tgt_z <= mem_z;
            end else if (r_state == S_TRACK) begin
                r_tgt_x <= accel_x;
                r_tgt_y <= accel_y;
                r_tgt_z <= accel_z;
            end

            if (w_slew_en) begin
                r_x <= slew(r_x, w_tgt_x);
                r_y <= slew(r_y, w_tgt_y);
                r_z <= slew(r_z, w_tgt_z);
            end
        end
    end

    assign mem_req  = (r_state == S_FETCH);
    assign mem_addr = r_mem_addr;
    assign x_cmd    = r_x;
    assign y_cmd    = r_y;
    assign z_cmd    = r_z;
    assign busy     = (r_state == S_FETCH) || (r_state == S_MOVE) ||
                      (r_state == S_DWELL) || (r_state == S_TRACK);
    assign done     = (r_state == S_DONE);
    assign state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_arm_motion_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_arm_motion_sequencer
// Purpose  : Self-checking bench: acking memory model plus a slew scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arm_motion_sequencer;

    logic       clk, rst, start, stop, select_source, mem_ack;
    logic [9:0] mem_x, mem_y, mem_z, accel_x, accel_y, accel_z;
    logic [9:0] x_cmd, y_cmd, z_cmd;
    logic [3:0] mem_addr;
    logic       mem_req, busy, done;
    logic [2:0] state;

    int total, bad, hs_count, tb_cnt;
    bit track_cmds;
    int m_x, m_y, m_z;
    logic [9:0] q_x[$], q_y[$], q_z[$];
    int q_addr[$];
    logic [9:0] px, py, pz;
    int pose_x[3] = '{530, 520, 500};
    int pose_y[3] = '{500, 510, 520};
    int pose_z[3] = '{512, 505, 512};

    arm_motion_sequencer #(
        .DATA_WIDTH(10), .ADDRESS_WIDTH(4), .NUM_POINTS(3), .TICK_DIV(4),
        .STEP_MAX(8), .DWELL_TICKS(2), .HOME(512)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .select_source(select_source),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_x(mem_x), .mem_y(mem_y), .mem_z(mem_z),
        .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
        .x_cmd(x_cmd), .y_cmd(y_cmd), .z_cmd(z_cmd),
        .busy(busy), .done(done), .state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference tick phase: 0 right after the cycle that carried a tick.
    always @(posedge clk) begin
        if (!rst) tb_cnt <= 0;
        else      tb_cnt <= (tb_cnt == 3) ? 0 : tb_cnt + 1;
    end

    task automatic model_move(input int tx, input int ty, input int tz);
        while (m_x != tx) begin
            if (tx > m_x) m_x = (tx - m_x > 8) ? m_x + 8 : tx;
            else          m_x = (m_x - tx > 8) ? m_x - 8 : tx;
            q_x.push_back(10'(m_x));
        end
        while (m_y != ty) begin
            if (ty > m_y) m_y = (ty - m_y > 8) ? m_y + 8 : ty;
            else          m_y = (m_y - ty > 8) ? m_y - 8 : ty;
            q_y.push_back(10'(m_y));
        end
        while (m_z != tz) begin
            if (tz > m_z) m_z = (tz - m_z > 8) ? m_z + 8 : tz;
            else          m_z = (m_z - tz > 8) ? m_z - 8 : tz;
            q_z.push_back(10'(m_z));
        end
    endtask

    // Scoreboard: every command change must be the next queued step, one cycle after a tick.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (rst && track_cmds) begin
                if (x_cmd !== px) begin
                    total++;
                    e = (q_x.size() != 0) ? q_x.pop_front() : 10'h3ff;
                    if (x_cmd !== e) begin bad++; $display("FAIL slew_x got=%0d exp=%0d", x_cmd, e); end
                    total++;
                    if (tb_cnt != 0) begin bad++; $display("FAIL slew_x_timing phase=%0d exp=0", tb_cnt); end
                end
                if (y_cmd !== py) begin
                    total++;
                    e = (q_y.size() != 0) ? q_y.pop_front() : 10'h3ff;
                    if (y_cmd !== e) begin bad++; $display("FAIL slew_y got=%0d exp=%0d", y_cmd, e); end
                end
                if (z_cmd !== pz) begin
                    total++;
                    e = (q_z.size() != 0) ? q_z.pop_front() : 10'h3ff;
                    if (z_cmd !== e) begin bad++; $display("FAIL slew_z got=%0d exp=%0d", z_cmd, e); end
                end
            end
            px = x_cmd; py = y_cmd; pz = z_cmd;
        end
    end

    // Memory model: acks the cycle after it sees a request, data from the pose table.
    initial begin
        int ea;
        forever begin
            @(negedge clk);
            if (rst && mem_req) begin
                @(negedge clk);
                if (rst && mem_req) begin
                    ea = (q_addr.size() != 0) ? q_addr.pop_front() : 0;
                    total++;
                    if (mem_addr !== 4'(ea)) begin
                        bad++; $display("FAIL fetch_addr got=%0d exp=%0d", mem_addr, ea);
                    end
                    mem_x = 10'(pose_x[ea % 3]);
                    mem_y = 10'(pose_y[ea % 3]);
                    mem_z = 10'(pose_z[ea % 3]);
                    mem_ack = 1'b1;
                    hs_count++;
                    if (track_cmds) model_move(pose_x[ea % 3], pose_y[ea % 3], pose_z[ea % 3]);
                    @(negedge clk);
                    mem_ack = 1'b0;
                    total++;
                    if (state !== 3'd2 || mem_req !== 1'b0) begin
                        bad++; $display("FAIL fetch_handshake state=%0d req=%0b exp state=2 req=0", state, mem_req);
                    end
                end
            end
        end
    end

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; stop = 1'b0; select_source = 1'b0;
        track_cmds = 1'b0;
        repeat (3) @(negedge clk);
        m_x = 512; m_y = 512; m_z = 512;
        q_x.delete(); q_y.delete(); q_z.delete(); q_addr.delete();
        hs_count = 0;
        total++;
        if (x_cmd !== 10'd512 || y_cmd !== 10'd512 || z_cmd !== 10'd512) begin
            bad++; $display("FAIL reset_cmds got=%0d/%0d/%0d exp=512", x_cmd, y_cmd, z_cmd);
        end
        total++;
        if (state !== 3'd0 || mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mem_addr !== 4'd0) begin
            bad++; $display("FAIL reset_ctrl state=%0d req=%0b busy=%0b done=%0b addr=%0d exp all 0",
                            state, mem_req, busy, done, mem_addr);
        end
        rst = 1'b1;
    endtask

    task automatic test_playback;
        int dones;
        bit finished;
        dones = 0; finished = 1'b0;
        test_reset();
        track_cmds = 1'b1;
        q_addr.push_back(0); q_addr.push_back(1); q_addr.push_back(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (mem_req !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL start_latency req=%0b busy=%0b exp 1/1", mem_req, busy);
        end
        for (int i = 0; i < 600 && !finished; i++) begin
            @(negedge clk);
            if (done) dones++;
            if (dones > 0 && state == 3'd0) finished = 1'b1;
        end
        total++;
        if (!finished) begin bad++; $display("FAIL playback_timeout state=%0d exp=0", state); end
        total++;
        if (dones != 1) begin bad++; $display("FAIL done_pulses got=%0d exp=1", dones); end
        total++;
        if (hs_count != 3 || q_addr.size() != 0) begin
            bad++; $display("FAIL fetch_count got=%0d exp=3", hs_count);
        end
        total++;
        if (mem_addr !== 4'd0) begin bad++; $display("FAIL end_addr got=%0d exp=0", mem_addr); end
        total++;
        if (x_cmd !== 10'd500 || y_cmd !== 10'd520 || z_cmd !== 10'd512 || q_x.size() + q_y.size() + q_z.size() != 0) begin
            bad++; $display("FAIL final_pose got=%0d/%0d/%0d exp=500/520/512", x_cmd, y_cmd, z_cmd);
        end
    endtask

    task automatic test_loop;
        bit hit;
        hit = 1'b0;
        test_reset();
        track_cmds = 1'b1;
        q_addr.push_back(0); q_addr.push_back(1); q_addr.push_back(2); q_addr.push_back(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 600 && !hit; i++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0) begin bad++; $display("FAIL loop_done got=%0b exp=0", done); end
            if (hs_count >= 4 && state == 3'd2) hit = 1'b1;
        end
        total++;
        if (!hit || q_addr.size() != 0) begin bad++; $display("FAIL loop_wrap fetches=%0d exp=4", hs_count); end
        track_cmds = 1'b0;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        total++;
        if (state !== 3'd0 || mem_req !== 1'b0) begin
            bad++; $display("FAIL loop_stop state=%0d req=%0b exp 0/0", state, mem_req);
        end
    endtask

    task automatic test_stop_move;
        bit hit, held;
        hit = 1'b0; held = 1'b1;
        test_reset();
        q_addr.push_back(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk);
            if (x_cmd == 10'd520) hit = 1'b1;
        end
        total++;
        if (!hit || state !== 3'd2 || y_cmd !== 10'd504) begin
            bad++; $display("FAIL stop_first_step state=%0d y=%0d exp state=2 y=504", state, y_cmd);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        total++;
        if (state !== 3'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL stop_idle state=%0d busy=%0b exp 0/0", state, busy);
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mem_req !== 1'b0 || x_cmd !== 10'd520 || y_cmd !== 10'd504 || z_cmd !== 10'd512) held = 1'b0;
        end
        total++;
        if (!held) begin
            bad++; $display("FAIL stop_frozen got=%0d/%0d/%0d req=%0b exp=520/504/512 req=0", x_cmd, y_cmd, z_cmd, mem_req);
        end
    endtask

    task automatic test_tracking;
        bit hit;
        hit = 1'b0;
        test_reset();
        track_cmds = 1'b1;
        accel_x = 10'd1023; accel_y = 10'd0; accel_z = 10'd512;
        model_move(1023, 0, 512);
        select_source = 1'b1;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            if (x_cmd == 10'd1023 && y_cmd == 10'd0) hit = 1'b1;
        end
        total++;
        if (!hit || state !== 3'd4 || q_x.size() + q_y.size() != 0) begin
            bad++; $display("FAIL track_limits got=%0d/%0d exp=1023/0", x_cmd, y_cmd);
        end
        accel_x = 10'd1020;
        model_move(1020, 0, 512);
        repeat (12) @(negedge clk);
        accel_x = 10'd1023;
        model_move(1023, 0, 512);
        repeat (12) @(negedge clk);
        total++;
        if (x_cmd !== 10'd1023 || q_x.size() != 0) begin
            bad++; $display("FAIL track_small_step got=%0d exp=1023", x_cmd);
        end
        select_source = 1'b0;
        @(negedge clk);
        total++;
        if (state !== 3'd0) begin bad++; $display("FAIL track_exit state=%0d exp=0", state); end
    endtask

    task automatic test_priority;
        test_reset();
        start = 1'b1; select_source = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (state !== 3'd4 || mem_req !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL prio_track state=%0d req=%0b busy=%0b exp 4/0/1", state, mem_req, busy);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total++;
        if (state !== 3'd4 || mem_req !== 1'b0) begin
            bad++; $display("FAIL start_in_track state=%0d req=%0b exp 4/0", state, mem_req);
        end
        select_source = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        total = 0; bad = 0; hs_count = 0;
        rst = 1'b0; start = 1'b0; stop = 1'b0; select_source = 1'b0; mem_ack = 1'b0;
        mem_x = '0; mem_y = '0; mem_z = '0;
        accel_x = 10'd512; accel_y = 10'd512; accel_z = 10'd512;
        test_reset();
`ifdef SEQ_LOOP_EN
        test_loop();
`else
        test_playback();
`endif
        test_stop_move();
        test_tracking();
        test_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
